// File: rtl/rv32v_hazard_ctrl.sv
// Stage-count-generic hazard controller for the RV32V vector pipeline.
// Produces per-stage stall/flush, a multi-cycle flush/drain sequence and a saturating stall counter.
module rv32v_hazard_ctrl #(
  parameter int NUM_STAGES   = 5,
  parameter int FLUSH_CYCLES = 1,
  parameter int CNT_W        = 16
) (
  input  logic                  CLK,
  input  logic                  nRST,
  input  logic [NUM_STAGES-1:0] busy,
  input  logic                  csr_update,
  input  logic                  exception,
  output logic [NUM_STAGES-1:0] stall,
  output logic [NUM_STAGES-1:0] flush,
  output logic                  ctrl_busy,
  output logic [CNT_W-1:0]      stall_count
);

  localparam int FCW = (FLUSH_CYCLES > 1) ? $clog2(FLUSH_CYCLES) : 1;
  localparam logic [FCW-1:0] FC_LOAD = FCW'(FLUSH_CYCLES - 1);

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    FLUSH = 2'd1,
    DRAIN = 2'd2
  } state_e;

  state_e                  state_q, state_d;
  logic [NUM_STAGES-1:0]   mask_q, mask_d;
  logic [FCW-1:0]          fcnt_q, fcnt_d;
  logic [NUM_STAGES-1:0]   flush_q;
  logic                    ctrl_busy_q;
  logic [CNT_W-1:0]        cnt_q;
  logic [NUM_STAGES-1:0]   busy_suffix_s;
  logic [NUM_STAGES-1:0]   evt_mask_s;
  logic                    evt_s;
  logic [NUM_STAGES-1:0]   stall_s;

  // Suffix OR: a busy stage holds itself and every stage upstream of it.
  always_comb begin
    logic acc;
    acc = 1'b0;
    for (int i = NUM_STAGES - 1; i >= 0; i--) begin
      acc              = acc | busy[i];
      busy_suffix_s[i] = acc;
    end
  end

  // Event decode; an exception outranks a CSR update and flushes the committing stage too.
  always_comb begin
    evt_s = exception | csr_update;
    if (exception) begin
      evt_mask_s = {NUM_STAGES{1'b1}};
    end else begin
      evt_mask_s = {1'b0, {(NUM_STAGES-1){1'b1}}};
    end
  end

  // Next-state logic for the flush/drain sequencer.
  always_comb begin
    state_d = state_q;
    mask_d  = mask_q;
    fcnt_d  = fcnt_q;
    case (state_q)
      IDLE: begin
        if (evt_s) begin
          state_d = FLUSH;
          mask_d  = evt_mask_s;
          fcnt_d  = FC_LOAD;
        end else begin
          state_d = IDLE;
        end
      end
      FLUSH: begin
        if (fcnt_q == {FCW{1'b0}}) begin
          state_d = (|busy) ? DRAIN : IDLE;
        end else begin
          fcnt_d = fcnt_q - {{(FCW-1){1'b0}}, 1'b1};
        end
      end
      DRAIN: begin
        if (evt_s) begin
          state_d = FLUSH;
          mask_d  = evt_mask_s;
          fcnt_d  = FC_LOAD;
        end else if (busy == {NUM_STAGES{1'b0}}) begin
          state_d = IDLE;
        end else begin
          state_d = DRAIN;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  // Stall is combinational; flush overrides it and drain freezes the whole pipe.
  always_comb begin
    case (state_q)
      IDLE:    stall_s = busy_suffix_s;
      FLUSH:   stall_s = {NUM_STAGES{1'b0}};
      DRAIN:   stall_s = {NUM_STAGES{1'b1}};
      default: stall_s = {NUM_STAGES{1'b0}};
    endcase
  end

  // State, registered flush/ctrl_busy outputs and the saturating stall counter.
  always_ff @(posedge CLK or negedge nRST) begin
    if (!nRST) begin
      state_q     <= IDLE;
      mask_q      <= {NUM_STAGES{1'b0}};
      fcnt_q      <= {FCW{1'b0}};
      flush_q     <= {NUM_STAGES{1'b0}};
      ctrl_busy_q <= 1'b0;
      cnt_q       <= {CNT_W{1'b0}};
    end else begin
      state_q     <= state_d;
      mask_q      <= mask_d;
      fcnt_q      <= fcnt_d;
      flush_q     <= (state_d == FLUSH) ? mask_d : {NUM_STAGES{1'b0}};
      ctrl_busy_q <= (state_d != IDLE);
      if (stall_s[0] && (cnt_q != {CNT_W{1'b1}})) begin
        cnt_q <= cnt_q + {{(CNT_W-1){1'b0}}, 1'b1};
      end else begin
        cnt_q <= cnt_q;
      end
    end
  end

  assign stall       = stall_s;
  assign flush       = flush_q;
  assign ctrl_busy   = ctrl_busy_q;
  assign stall_count = cnt_q;

endmodule

// File: tb/tb_rv32v_hazard_ctrl.sv
// Directed bench for rv32v_hazard_ctrl: one instance with FLUSH_CYCLES=2, one with FLUSH_CYCLES=1 and CNT_W=4.
module tb_rv32v_hazard_ctrl;

  logic       CLK;
  logic       nRST;
  logic [4:0] a_busy, b_busy;
  logic       a_csr, a_exc, b_csr, b_exc;
  logic [4:0] a_stall, a_flush, b_stall, b_flush;
  logic       a_cb, b_cb;
  logic [15:0] a_cnt;
  logic [3:0]  b_cnt;

  int n_tests = 0;
  int n_fail  = 0;

  rv32v_hazard_ctrl #(.NUM_STAGES(5), .FLUSH_CYCLES(2), .CNT_W(16)) dut_a (
    .CLK(CLK), .nRST(nRST), .busy(a_busy), .csr_update(a_csr), .exception(a_exc),
    .stall(a_stall), .flush(a_flush), .ctrl_busy(a_cb), .stall_count(a_cnt)
  );

  rv32v_hazard_ctrl #(.NUM_STAGES(5), .FLUSH_CYCLES(1), .CNT_W(4)) dut_b (
    .CLK(CLK), .nRST(nRST), .busy(b_busy), .csr_update(b_csr), .exception(b_exc),
    .stall(b_stall), .flush(b_flush), .ctrl_busy(b_cb), .stall_count(b_cnt)
  );

  initial CLK = 1'b0;
  always #5 CLK = ~CLK;

  task automatic chk_eq(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_tests++;
    if (obs !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge CLK);
    #1;
  endtask

  initial begin
    nRST = 1'b0;
    a_busy = 5'b0; a_csr = 1'b0; a_exc = 1'b0;
    b_busy = 5'b0; b_csr = 1'b0; b_exc = 1'b0;
    #12;
    chk_eq("rst_flush", 32'(a_flush), 32'h0);
    chk_eq("rst_stall", 32'(a_stall), 32'h0);
    chk_eq("rst_cb",    32'(a_cb),    32'h0);
    chk_eq("rst_cnt",   32'(a_cnt),   32'h0);
    nRST = 1'b1;
    tick();

    // Test 1: stall pattern and counting
    a_busy = 5'b00100; #1;
    chk_eq("t1_stall", 32'(a_stall), 32'h07);
    chk_eq("t1_flush", 32'(a_flush), 32'h00);
    chk_eq("t1_cb",    32'(a_cb),    32'h0);
    tick(); tick(); tick();
    chk_eq("t1_cnt3",  32'(a_cnt),   32'd3);
    a_busy = 5'b10000; #1;
    chk_eq("t1_stall_top", 32'(a_stall), 32'h1F);
    a_busy = 5'b00001; #1;
    chk_eq("t1_stall_bot", 32'(a_stall), 32'h01);
    a_busy = 5'b00000; #1;
    chk_eq("t1_stall_none", 32'(a_stall), 32'h00);

    // Test 2: exception, FLUSH_CYCLES=2, busy=0
    a_exc = 1'b1; tick(); a_exc = 1'b0;
    chk_eq("t2_flush_k1", 32'(a_flush), 32'h1F);
    chk_eq("t2_stall_k1", 32'(a_stall), 32'h00);
    chk_eq("t2_cb_k1",    32'(a_cb),    32'h1);
    tick();
    chk_eq("t2_flush_k2", 32'(a_flush), 32'h1F);
    chk_eq("t2_stall_k2", 32'(a_stall), 32'h00);
    tick();
    chk_eq("t2_flush_end", 32'(a_flush), 32'h00);
    tick();
    chk_eq("t2_cb_end",   32'(a_cb),    32'h0);
    chk_eq("t2_cnt_hold", 32'(a_cnt),   32'd3);

    // Test 3: priority and csr-only mask
    b_exc = 1'b1; b_csr = 1'b1; tick(); b_exc = 1'b0; b_csr = 1'b0;
    chk_eq("t3_both", 32'(b_flush), 32'h1F);
    tick();
    chk_eq("t3_both_end", 32'(b_flush), 32'h00);
    chk_eq("t3_both_cb",  32'(b_cb),    32'h0);
    b_csr = 1'b1; tick(); b_csr = 1'b0;
    chk_eq("t3_csr", 32'(b_flush), 32'h0F);
    tick();
    chk_eq("t3_csr_end", 32'(b_flush), 32'h00);

    // Test 4: drain while busy[3] is held
    b_busy = 5'b01000; #1;
    chk_eq("t4_idle_stall", 32'(b_stall), 32'h0F);
    b_exc = 1'b1; tick(); b_exc = 1'b0;
    chk_eq("t4_flush",       32'(b_flush), 32'h1F);
    chk_eq("t4_flush_stall", 32'(b_stall), 32'h00);
    for (int i = 0; i < 3; i++) begin
      tick();
      chk_eq("t4_drain_stall", 32'(b_stall), 32'h1F);
      chk_eq("t4_drain_flush", 32'(b_flush), 32'h00);
      chk_eq("t4_drain_cb",    32'(b_cb),    32'h1);
    end
    b_busy = 5'b00000; #1;
    chk_eq("t4_drain_hold", 32'(b_stall), 32'h1F);
    tick();
    chk_eq("t4_idle_cb",    32'(b_cb),    32'h0);
    chk_eq("t4_idle_stall2", 32'(b_stall), 32'h00);

    // Test 5a: csr_update during drain restarts the flush
    b_busy = 5'b01000;
    b_exc = 1'b1; tick(); b_exc = 1'b0;
    tick();
    chk_eq("t5_drain", 32'(b_stall), 32'h1F);
    b_csr = 1'b1; tick(); b_csr = 1'b0;
    chk_eq("t5_reflush",   32'(b_flush), 32'h0F);
    chk_eq("t5_reflush_st", 32'(b_stall), 32'h00);
    tick();
    chk_eq("t5_redrain", 32'(b_flush), 32'h00);
    chk_eq("t5_redrain_st", 32'(b_stall), 32'h1F);
    b_busy = 5'b00000; tick();
    chk_eq("t5_idle", 32'(b_cb), 32'h0);

    // Test 5b: exception during flush is ignored
    a_csr = 1'b1; tick(); a_csr = 1'b0; a_exc = 1'b1;
    chk_eq("t5_ign_k1", 32'(a_flush), 32'h0F);
    tick(); a_exc = 1'b0;
    chk_eq("t5_ign_k2", 32'(a_flush), 32'h0F);
    tick();
    chk_eq("t5_ign_end", 32'(a_flush), 32'h00);
    tick();
    chk_eq("t5_ign_cb", 32'(a_cb), 32'h0);

    // Test 6: saturation, then reset mid-flush
    nRST = 1'b0; #2; nRST = 1'b1;
    chk_eq("t6_cnt_clr", 32'(b_cnt), 32'h0);
    b_busy = 5'b00001;
    for (int i = 0; i < 14; i++) tick();
    chk_eq("t6_cnt14", 32'(b_cnt), 32'd14);
    for (int i = 0; i < 6; i++) tick();
    chk_eq("t6_cnt_sat", 32'(b_cnt), 32'd15);
    b_busy = 5'b00000;
    b_exc = 1'b1; tick(); b_exc = 1'b0;
    chk_eq("t6_flush_pre", 32'(b_flush), 32'h1F);
    #2 nRST = 1'b0; #1;
    chk_eq("t6_rst_flush", 32'(b_flush), 32'h00);
    chk_eq("t6_rst_cnt",   32'(b_cnt),   32'h0);
    chk_eq("t6_rst_cb",    32'(b_cb),    32'h0);
    #2 nRST = 1'b1;
    tick();
    chk_eq("t6_post_flush", 32'(b_flush), 32'h00);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
